myo_spi_sequencer: RTL and testbench
====================================

# myo_spi_sequencer

Multi-channel successor to the single-word SPI control FSM: sweeps a frame of `FRAME_WORDS` words over each enabled motor board of `NUM_CHANNELS`, driving the existing SPI master's write/read handshake and a per-channel active-low slave select. It sits between the HPS-facing register file (supplies TX words, consumes RX words) and one shared SPI master. It adds channel enables, configurable frame length, setup/hold/gap timing, per-channel timeout with error reporting, and sweep completion signalling.

## Interface
- `DATA_WIDTH`, 16: SPI word width; must match the SPI master.
- `NUM_CHANNELS`, 4: number of slave boards, 1..16.
- `FRAME_WORDS`, 12: words per channel frame, 1..255.
- `SS_SETUP`, 4: clocks from `ss_n` low to first `wren`.
- `SS_HOLD`, 4: clocks from last RX word to `ss_n` high.
- `SS_GAP`, 8: clocks with all `ss_n` high between channels.
- `TIMEOUT`, 4096: clocks without `write_ack`/`data_read_valid` before a channel is aborted.

Ports:
- `clock` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; rising edge starts a sweep.
- `channel_enable` in NUM_CHANNELS: channels to include; sampled at sweep start.
- `tx_word` in DATA_WIDTH: word at (`tx_channel`, `tx_index`), valid combinationally.
- `tx_channel` out clog2(NUM_CHANNELS): current channel.
- `tx_index` out 8: index of word being loaded.
- `di_req` in 1, `write_ack` in 1, `data_read_valid` in 1, `data_read` in DATA_WIDTH: from SPI master.
- `Word` out DATA_WIDTH, `wren` out 1: to SPI master.
- `ss_n` out NUM_CHANNELS: per-channel slave select, at most one bit low.
- `rx_valid` out 1, `rx_channel` out clog2(NUM_CHANNELS), `rx_index` out 8, `rx_data` out DATA_WIDTH: one-cycle RX strobe and payload.
- `busy` out 1, `done` out 1 (one-cycle pulse), `error` out NUM_CHANNELS (sticky timeout flags, cleared at sweep start).

## Operation
- States: IDLE, SETUP, LOAD, WAIT_REQ, DRAIN, HOLD, GAP.
- IDLE: on `start` rising edge latch `channel_enable`, clear `error`, set `busy`, select lowest enabled channel → SETUP. No channel enabled → `done` pulse next cycle, stay IDLE.
- SETUP: drive that channel's `ss_n` low; count `SS_SETUP` → LOAD.
- LOAD: `Word`=`tx_word`, `wren`=1, held stable until `write_ack` sampled high; then `wren`=0, `tx_index`++ → WAIT_REQ (or DRAIN if all words loaded).
- WAIT_REQ: on `di_req` high → LOAD.
- Every `data_read_valid` during a frame: register `rx_data`, `rx_index` (0-based RX count), `rx_channel`, pulse `rx_valid`. RX count reaching `FRAME_WORDS` in DRAIN → HOLD.
- HOLD: `SS_HOLD` clocks, then `ss_n` all high → GAP.
- GAP: `SS_GAP` clocks; next enabled channel → SETUP; none → `done`, clear `busy` → IDLE.
- Timeout counter restarts at every `write_ack`/`data_read_valid` and state entry; expiry in LOAD/WAIT_REQ/DRAIN sets `error[ch]`, drops `wren` → HOLD.
- `start` while `busy` ignored; `data_read_valid` outside SETUP..DRAIN ignored.

## Timing
- Reset values: `ss_n` all 1; `wren`, `busy`, `done`, `rx_valid`, `error` 0; `Word`, `rx_data`, indices, channels 0; state IDLE.
- Reset mid-frame: all outputs to reset values immediately (async), no further SPI activity.
- `start` edge at cycle 0 → `busy`=1 and `ss_n[ch]`=0 at cycle 1 → `wren`=1 at cycle 1+`SS_SETUP`.
- `wren` low the cycle after `write_ack` sampled; `write_ack` and `di_req` same cycle: ack handled first, request taken next cycle.
- `rx_valid` one cycle after `data_read_valid`.
- `done` asserted the cycle `busy` falls.
- Channel order ascending; no `ss_n` overlap; ≥`SS_GAP` clocks all-high between channels.

## Test plan
- NUM_CHANNELS=4, FRAME_WORDS=3, enable=4'b0101, SPI master model: exactly 6 `wren`/`write_ack`, `ss_n` goes 1110 then 1011, 6 `rx_valid` with `rx_channel` 0,0,0,2,2,2, `rx_index` 0,1,2, one `done`.
- enable=0, `start` → `done` at cycle 1, `ss_n`=4'b1111 throughout, `wren` never high.
- Slave model withholds `write_ack` on channel 1 → `error`=4'b0010 after `TIMEOUT`, channel 2 still serviced, `done` pulses.
- `reset_n` low in LOAD of word 5 → same cycle `ss_n`=4'b1111, `wren`=0, `busy`=0; new `start` resumes at channel 0 index 0.
- `start` re-pulsed mid-sweep and spurious `data_read_valid` in GAP → ignored: no extra `rx_valid`, single `done`.
- `write_ack` with `di_req` same cycle, `SS_SETUP`=1 → `Word` changes only after `wren` deasserts; `wren` at exactly cycle 2 after `start`.

Source files
------------

// File: rtl/myo_spi_sequencer.sv
// myo_spi_sequencer: sweeps a fixed-length SPI frame over each enabled motor
// board. It drives one shared SPI master through its wren/write_ack/di_req
// handshake and reports received words, per-channel timeouts and sweep
// completion.
module myo_spi_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int FRAME_WORDS  = 12,
    parameter int SS_SETUP     = 4,
    parameter int SS_HOLD      = 4,
    parameter int SS_GAP       = 8,
    parameter int TIMEOUT      = 4096,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [NUM_CHANNELS-1:0] channel_enable,
    input  logic [DATA_WIDTH-1:0]   tx_word,
    output logic [CH_W-1:0]         tx_channel,
    output logic [7:0]              tx_index,
    input  logic                    di_req,
    input  logic                    write_ack,
    input  logic                    data_read_valid,
    input  logic [DATA_WIDTH-1:0]   data_read,
    output logic [DATA_WIDTH-1:0]   Word,
    output logic                    wren,
    output logic [NUM_CHANNELS-1:0] ss_n,
    output logic                    rx_valid,
    output logic [CH_W-1:0]         rx_channel,
    output logic [7:0]              rx_index,
    output logic [DATA_WIDTH-1:0]   rx_data,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CHANNELS-1:0] error
);

    // One shared counter times setup/hold/gap and the inactivity timeout.
    localparam int CNT_W = $clog2(TIMEOUT + SS_SETUP + SS_HOLD + SS_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_LOAD     = 3'd2,
        S_WAIT_REQ = 3'd3,
        S_DRAIN    = 3'd4,
        S_HOLD     = 3'd5,
        S_GAP      = 3'd6
    } state_e;

    // Lowest set bit of mask at or above 'from'; MSB of the result is "found".
    function automatic logic [CH_W:0] find_ch(input logic [NUM_CHANNELS-1:0] mask, input int from);
        logic [CH_W:0] res;
        res = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if ((i >= from) && mask[i]) begin
                res = {1'b1, CH_W'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Active-low select vector with only channel ch driven low.
    function automatic logic [NUM_CHANNELS-1:0] sel_n(input logic [CH_W-1:0] ch);
        logic [NUM_CHANNELS-1:0] v;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            v[i] = (CH_W'(i) != ch);
        end
        return v;
    endfunction

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [NUM_CHANNELS-1:0] ena_q, ena_d;
    logic [7:0]              tx_idx_q, tx_idx_d;
    logic [8:0]              rx_cnt_q, rx_cnt_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic                    wren_q, wren_d;
    logic [NUM_CHANNELS-1:0] ss_n_q, ss_n_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [CH_W-1:0]         rx_channel_q, rx_channel_d;
    logic [7:0]              rx_index_q, rx_index_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [NUM_CHANNELS-1:0] error_q, error_d;
    logic                    start_q, start_d;

    logic                    start_rise_s;
    logic                    in_frame_s;
    logic                    active_s;
    logic                    event_s;
    logic                    tmo_s;
    logic [CH_W:0]           pick_s;
    logic [8:0]              tx_next_s;

    // Next-state, datapath and output computation for the sweep sequencer.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        ena_d        = ena_q;
        tx_idx_d     = tx_idx_q;
        rx_cnt_d     = rx_cnt_q;
        word_d       = word_q;
        wren_d       = wren_q;
        ss_n_d       = ss_n_q;
        rx_valid_d   = 1'b0;
        rx_channel_d = rx_channel_q;
        rx_index_d   = rx_index_q;
        rx_data_d    = rx_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        start_d      = start;
        pick_s       = '0;
        cnt_d        = cnt_q;

        start_rise_s = start && !start_q;
        in_frame_s   = (state_q == S_SETUP) || (state_q == S_LOAD) ||
                       (state_q == S_WAIT_REQ) || (state_q == S_DRAIN);
        active_s     = (state_q == S_LOAD) || (state_q == S_WAIT_REQ) || (state_q == S_DRAIN);
        event_s      = active_s && (write_ack || data_read_valid);
        tmo_s        = (cnt_q == CNT_W'(TIMEOUT - 1)) && !event_s;
        tx_next_s    = {1'b0, tx_idx_q} + 9'd1;

        // Received words are only meaningful while a slave is selected.
        if (in_frame_s && data_read_valid) begin
            rx_valid_d   = 1'b1;
            rx_data_d    = data_read;
            rx_index_d   = rx_cnt_q[7:0];
            rx_channel_d = ch_q;
            rx_cnt_d     = rx_cnt_q + 9'd1;
        end else begin
            rx_valid_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_rise_s) begin
                    ena_d   = channel_enable;
                    error_d = '0;
                    pick_s  = find_ch(channel_enable, 0);
                    if (pick_s[CH_W]) begin
                        ch_d     = pick_s[CH_W-1:0];
                        ss_n_d   = sel_n(pick_s[CH_W-1:0]);
                        busy_d   = 1'b1;
                        tx_idx_d = 8'd0;
                        rx_cnt_d = 9'd0;
                        state_d  = S_SETUP;
                    end else begin
                        done_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(SS_SETUP - 1)) begin
                    word_d  = tx_word;
                    wren_d  = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_LOAD: begin
                // Acknowledge wins over any simultaneous request; the request
                // is taken from WAIT_REQ on the following cycle.
                if (write_ack) begin
                    wren_d   = 1'b0;
                    tx_idx_d = tx_next_s[7:0];
                    state_d  = (tx_next_s >= 9'(FRAME_WORDS)) ? S_DRAIN : S_WAIT_REQ;
                end else if (tmo_s) begin
                    wren_d         = 1'b0;
                    error_d[ch_q]  = 1'b1;
                    state_d        = S_HOLD;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_WAIT_REQ: begin
                if (di_req) begin
                    word_d  = tx_word;
                    wren_d  = 1'b1;
                    state_d = S_LOAD;
                end else if (tmo_s) begin
                    error_d[ch_q] = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    state_d = S_WAIT_REQ;
                end
            end
            S_DRAIN: begin
                if (rx_cnt_d >= 9'(FRAME_WORDS)) begin
                    state_d = S_HOLD;
                end else if (tmo_s) begin
                    error_d[ch_q] = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(SS_HOLD - 1)) begin
                    ss_n_d  = '1;
                    state_d = S_GAP;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(SS_GAP - 1)) begin
                    pick_s = find_ch(ena_q, int'(ch_q) + 1);
                    if (pick_s[CH_W]) begin
                        ch_d     = pick_s[CH_W-1:0];
                        ss_n_d   = sel_n(pick_s[CH_W-1:0]);
                        tx_idx_d = 8'd0;
                        rx_cnt_d = 9'd0;
                        state_d  = S_SETUP;
                    end else begin
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else begin
                    state_d = S_GAP;
                end
            end
            default: begin
                state_d = S_IDLE;
                wren_d  = 1'b0;
                ss_n_d  = '1;
                busy_d  = 1'b0;
            end
        endcase

        // The counter restarts on every state entry and on SPI activity.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (event_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ch_q         <= '0;
            ena_q        <= '0;
            tx_idx_q     <= 8'd0;
            rx_cnt_q     <= 9'd0;
            word_q       <= '0;
            wren_q       <= 1'b0;
            ss_n_q       <= '1;
            rx_valid_q   <= 1'b0;
            rx_channel_q <= '0;
            rx_index_q   <= 8'd0;
            rx_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= '0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            ena_q        <= ena_d;
            tx_idx_q     <= tx_idx_d;
            rx_cnt_q     <= rx_cnt_d;
            word_q       <= word_d;
            wren_q       <= wren_d;
            ss_n_q       <= ss_n_d;
            rx_valid_q   <= rx_valid_d;
            rx_channel_q <= rx_channel_d;
            rx_index_q   <= rx_index_d;
            rx_data_q    <= rx_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            start_q      <= start_d;
        end
    end

    assign tx_channel = ch_q;
    assign tx_index   = tx_idx_q;
    assign Word       = word_q;
    assign wren       = wren_q;
    assign ss_n       = ss_n_q;
    assign rx_valid   = rx_valid_q;
    assign rx_channel = rx_channel_q;
    assign rx_index   = rx_index_q;
    assign rx_data    = rx_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_myo_spi_sequencer.sv
// Scoreboard bench for myo_spi_sequencer: an SPI master model answers the
// handshake, expected RX words / done pulses are queued by the stimulus and
// popped by an independent monitor.
module tb_myo_spi_sequencer;

    localparam int DW   = 16;
    localparam int NC   = 4;
    localparam int FW   = 3;
    localparam int SETUP = 1;
    localparam int HOLD = 2;
    localparam int GAP  = 3;
    localparam int TMO  = 40;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [NC-1:0] channel_enable = '0;
    logic [DW-1:0] tx_word;
    logic [1:0]    tx_channel;
    logic [7:0]    tx_index;
    logic          di_req = 1'b0;
    logic          write_ack = 1'b0;
    logic          data_read_valid = 1'b0;
    logic [DW-1:0] data_read = '0;
    logic [DW-1:0] Word;
    logic          wren;
    logic [NC-1:0] ss_n;
    logic          rx_valid;
    logic [1:0]    rx_channel;
    logic [7:0]    rx_index;
    logic [DW-1:0] rx_data;
    logic          busy;
    logic          done;
    logic [NC-1:0] error;

    myo_spi_sequencer #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .FRAME_WORDS(FW),
        .SS_SETUP(SETUP), .SS_HOLD(HOLD), .SS_GAP(GAP), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .channel_enable(channel_enable), .tx_word(tx_word),
        .tx_channel(tx_channel), .tx_index(tx_index), .di_req(di_req),
        .write_ack(write_ack), .data_read_valid(data_read_valid),
        .data_read(data_read), .Word(Word), .wren(wren), .ss_n(ss_n),
        .rx_valid(rx_valid), .rx_channel(rx_channel), .rx_index(rx_index),
        .rx_data(rx_data), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    // TX word table: 0xA000 | channel<<8 | index.
    assign tx_word = {6'b101000, tx_channel, tx_index};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wren_rises = 0;
    int ack_count = 0;
    int done_count = 0;
    int exp_done = 0;
    int ss_overlap = 0;
    int withhold = -1;
    logic spur_req = 1'b0;
    logic [25:0] exp_rx[$];
    logic [NC-1:0] ss_seen[$];
    int rx_due[$];
    logic [DW-1:0] rx_val[$];
    logic acked = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] txw(input int ch, input int idx);
        logic [1:0] c;
        logic [7:0] i;
        c = ch[1:0];
        i = idx[7:0];
        return {6'b101000, c, i};
    endfunction

    task automatic push_frame(input int ch);
        logic [1:0] c;
        logic [7:0] i;
        for (int k = 0; k < FW; k++) begin
            c = ch[1:0];
            i = k[7:0];
            exp_rx.push_back({c, i, ~txw(ch, k)});
        end
    endtask

    function automatic int cur_ch(input logic [NC-1:0] s);
        int r;
        r = -1;
        for (int i = 0; i < NC; i++) if (!s[i]) r = i;
        return r;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // SPI master model: acks each wren once, raises di_req with the ack,
    // returns ~Word three cycles later.
    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_ack = 1'b0; data_read_valid = 1'b0; di_req = 1'b0;
            data_read = '0; acked = 1'b0; spur_req = 1'b0;
            rx_due.delete(); rx_val.delete();
        end else begin
            write_ack = 1'b0;
            data_read_valid = 1'b0;
            if (spur_req) begin
                data_read_valid = 1'b1; data_read = 16'hDEAD; spur_req = 1'b0;
            end else if (rx_due.size() > 0 && rx_due[0] <= cyc) begin
                data_read_valid = 1'b1;
                data_read = rx_val.pop_front();
                void'(rx_due.pop_front());
            end
            if (wren && !acked && cur_ch(ss_n) != withhold) begin
                write_ack = 1'b1; acked = 1'b1; di_req = 1'b1; ack_count++;
                rx_due.push_back(cyc + 3);
                rx_val.push_back(~Word);
            end else if (!wren) begin
                acked = 1'b0;
            end
            if (ss_n == 4'hF) di_req = 1'b0;
        end
    end

    logic          prev_wren = 1'b0;
    logic [NC-1:0] prev_ss = 4'hF;
    logic [DW-1:0] wr_word = '0;
    logic          wr_changed = 1'b0;
    logic          had_low = 1'b0;
    int            hi_run = 0;
    logic [25:0]   e;

    // Monitor: pops expectations on rx_valid/done and watches handshake rules.
    always @(posedge clock) begin
        #1;
        if (!reset_n) begin
            prev_wren = 1'b0; prev_ss = 4'hF; had_low = 1'b0; hi_run = 0; wr_changed = 1'b0;
        end else begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rx_unexpected actual ch=%0d idx=%0d data=%h required none",
                             rx_channel, rx_index, rx_data);
                end else begin
                    e = exp_rx.pop_front();
                    chk("rx_payload", 32'({rx_channel, rx_index, rx_data}), 32'(e));
                end
            end
            if (done) begin
                done_count++;
                checks++;
                if (exp_done > 0) exp_done--;
                else begin
                    failures++;
                    $display("FAIL done_unexpected actual=1 required=0");
                end
            end
            if (wren && !prev_wren) begin
                wren_rises++; wr_word = Word; wr_changed = 1'b0;
            end else if (wren && prev_wren) begin
                if (Word !== wr_word) wr_changed = 1'b1;
            end else if (!wren && prev_wren) begin
                chk("word_stable_during_wren", 32'(wr_changed), 32'd0);
            end
            if ($countones(~ss_n) > 1) ss_overlap++;
            if (ss_n != prev_ss && ss_n != 4'hF) ss_seen.push_back(ss_n);
            if (ss_n == 4'hF) hi_run++;
            else begin
                if (prev_ss == 4'hF && had_low) chk("ss_gap_min", 32'(hi_run >= GAP), 32'd1);
                had_low = 1'b1;
                hi_run = 0;
            end
            if (!busy && ss_n == 4'hF) had_low = 1'b0;
            prev_wren = wren;
            prev_ss = ss_n;
        end
    end

    task automatic wait_done(input int max, input string nm);
        int base;
        int n;
        base = done_count;
        n = 0;
        while (done_count == base && n < max) begin
            @(negedge clock);
            n++;
        end
        chk({nm, "_done_seen"}, 32'(done_count != base), 32'd1);
    endtask

    int base_r, base_a, base_d, n, t_load, t_err;

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ss_n", 32'(ss_n), 32'hF);
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_word", 32'(Word), 32'd0);
        chk("rst_tx_pos", 32'({tx_channel, tx_index}), 32'd0);
        chk("rst_rx_pos", 32'({rx_channel, rx_index, rx_data}), 32'd0);
        @(negedge clock); reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // T1: enable 0101, full sweep, setup latency
        ss_seen.delete(); ss_overlap = 0;
        base_r = wren_rises; base_a = ack_count;
        push_frame(0); push_frame(2); exp_done++;
        channel_enable = 4'b0101; start = 1'b1;
        @(posedge clock); #1;
        chk("t1_busy_c1", 32'(busy), 32'd1);
        chk("t1_ssn_c1", 32'(ss_n), 32'hE);
        chk("t1_wren_c1", 32'(wren), 32'd0);
        @(posedge clock); #1;
        chk("t1_wren_c2", 32'(wren), 32'd1);
        chk("t1_word_c2", 32'(Word), 32'hA000);
        start = 1'b0;
        wait_done(2000, "t1");
        repeat (5) @(negedge clock);
        chk("t1_wren_count", 32'(wren_rises - base_r), 32'd6);
        chk("t1_ack_count", 32'(ack_count - base_a), 32'd6);
        chk("t1_ss_patterns", 32'(ss_seen.size()), 32'd2);
        chk("t1_ss_first", 32'((ss_seen.size() > 0) ? ss_seen[0] : 4'h0), 32'hE);
        chk("t1_ss_second", 32'((ss_seen.size() > 1) ? ss_seen[1] : 4'h0), 32'hB);
        chk("t1_ss_overlap", 32'(ss_overlap), 32'd0);
        chk("t1_rx_left", 32'(exp_rx.size()), 32'd0);
        chk("t1_done_left", 32'(exp_done), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_error", 32'(error), 32'd0);

        // T2: nothing enabled
        ss_seen.delete(); base_r = wren_rises; exp_done++;
        @(negedge clock); channel_enable = 4'b0000; start = 1'b1;
        @(posedge clock); #1;
        chk("t2_done_c1", 32'(done), 32'd1);
        chk("t2_busy_c1", 32'(busy), 32'd0);
        start = 1'b0;
        repeat (10) @(negedge clock);
        chk("t2_ss_never_low", 32'(ss_seen.size()), 32'd0);
        chk("t2_no_wren", 32'(wren_rises - base_r), 32'd0);
        chk("t2_done_left", 32'(exp_done), 32'd0);

        // T3: channel 1 never acked -> timeout error, channel 2 still served
        withhold = 1;
        push_frame(0); push_frame(2); exp_done++;
        @(negedge clock); channel_enable = 4'b0111; start = 1'b1;
        @(negedge clock); start = 1'b0;
        n = 0;
        while (!(wren && ss_n == 4'hD) && n < 500) begin @(posedge clock); #2; n++; end
        chk("t3_ch1_load_seen", 32'(n < 500), 32'd1);
        t_load = cyc;
        n = 0;
        while (!error[1] && n < 500) begin @(posedge clock); #2; n++; end
        t_err = cyc;
        chk("t3_timeout_cycles", 32'(t_err - t_load), 32'(TMO));
        wait_done(2000, "t3");
        repeat (5) @(negedge clock);
        chk("t3_error", 32'(error), 32'h2);
        chk("t3_rx_left", 32'(exp_rx.size()), 32'd0);
        withhold = -1;

        // T4: reset during LOAD of the fifth word, then restart
        base_r = wren_rises;
        push_frame(0);
        @(negedge clock); channel_enable = 4'b0101; start = 1'b1;
        @(posedge clock); #1;
        chk("t4_error_cleared", 32'(error), 32'd0);
        start = 1'b0;
        n = 0;
        while (!(wren_rises - base_r == 5 && wren) && n < 500) begin @(posedge clock); #2; n++; end
        chk("t4_word5_pos", 32'({tx_channel, tx_index}), 32'h201);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_ss_n", 32'(ss_n), 32'hF);
        chk("t4_rst_wren", 32'(wren), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rx_left", 32'(exp_rx.size()), 32'd0);
        repeat (2) @(negedge clock); reset_n = 1'b1;
        repeat (2) @(negedge clock);
        base_r = wren_rises;
        push_frame(0); push_frame(2); exp_done++;
        channel_enable = 4'b0101; start = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("t4_restart_wren", 32'(wren), 32'd1);
        chk("t4_restart_pos", 32'({tx_channel, tx_index}), 32'd0);
        chk("t4_restart_word", 32'(Word), 32'hA000);
        start = 1'b0;
        wait_done(2000, "t4");
        repeat (5) @(negedge clock);
        chk("t4_wren_count", 32'(wren_rises - base_r), 32'd6);
        chk("t4_rx_left_end", 32'(exp_rx.size()), 32'd0);

        // T5: start re-pulsed while busy, spurious data_read_valid in GAP
        base_d = done_count;
        push_frame(0); push_frame(2); exp_done++;
        @(negedge clock); channel_enable = 4'b0101; start = 1'b1;
        n = 0;
        while (ss_n != 4'hE && n < 100) begin @(posedge clock); #2; n++; end
        start = 1'b0;
        @(posedge clock); #2; start = 1'b1;
        n = 0;
        while (!(busy && ss_n == 4'hF) && n < 500) begin @(posedge clock); #2; n++; end
        chk("t5_gap_reached", 32'(n < 500), 32'd1);
        spur_req = 1'b1;
        wait_done(2000, "t5");
        repeat (20) @(negedge clock);
        chk("t5_single_done", 32'(done_count - base_d), 32'd1);
        chk("t5_rx_left", 32'(exp_rx.size()), 32'd0);
        chk("t5_busy_end", 32'(busy), 32'd0);
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
